// File: rtl/adc_rail_filter.sv
// ---------------------------------------------------------------------------
// adc_rail_filter
//   Supervises two supply rails sampled by a shared ADC. Conversions tagged
//   with CH_A / CH_B are averaged (2^AVG_LOG2 samples per result), outliers
//   against the last average are rejected, and a watchdog flags a rail as
//   stale when no sample has been accepted for TIMEOUT cycles.
//
// Ports
//   clk          in   system clock, rising edge
//   reset_in_n   in   asynchronous active-low reset (released synchronously
//                     upstream, so the first cycle after release is usable)
//   adc_data     in   16-bit conversion result, 12-bit code in [15:4]
//   adc_channel  in   channel tag of adc_data
//   adc_eoc      in   single-cycle strobe qualifying adc_data/adc_channel
//   volt_a/b     out  averaged code per rail, held between updates
//   drdy_a/b     out  one-cycle pulse when the matching volt output updates
//   stale_a/b    out  level, rail watchdog has reached TIMEOUT
//   reject_cnt   out  spike-rejected samples of both rails, saturating at 255
//
// AVG_LOG2 is meant to be 1..4.
// ---------------------------------------------------------------------------

// Per-rail averager, spike filter and watchdog.
module adc_rail_chan #(
  parameter logic [4:0]  CH          = 5'd16,
  parameter int          AVG_LOG2    = 2,
  parameter logic [11:0] SPIKE_LIMIT = 12'd400,
  parameter logic [19:0] TIMEOUT     = 20'd100000
) (
  input  logic        clk,
  input  logic        reset_in_n,
  input  logic [11:0] code,
  input  logic [4:0]  adc_channel,
  input  logic        adc_eoc,
  output logic [11:0] volt,
  output logic        drdy,
  output logic        stale,
  output logic        reject
);
  localparam int ACC_W = 12 + AVG_LOG2;
  localparam logic [AVG_LOG2-1:0] CNT_LAST = '1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    RUN   = 2'd1,
    STALE = 2'd2
  } state_t;

  state_t               state_r, state_nxt_s;
  logic [ACC_W-1:0]     acc_r;
  logic [AVG_LOG2-1:0]  cnt_r;
  logic [19:0]          wd_r, wd_nxt_s;
  logic [11:0]          volt_r;
  logic                 drdy_r, stale_r;
  logic                 hit_s, primed_s, spike_s, accept_s, reject_s, complete_s;
  logic [ACC_W-1:0]     sum_s;

  // |a - b| evaluated at 13-bit signed width so both directions are exact.
  function automatic logic [12:0] abs_diff(input logic [11:0] a, input logic [11:0] b);
    logic signed [12:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    if (d < 13'sd0) begin
      abs_diff = -d;
    end else begin
      abs_diff = d;
    end
  endfunction

  assign hit_s    = adc_eoc && (adc_channel == CH);
  assign primed_s = (state_r == RUN);
  assign spike_s  = abs_diff(code, volt_r) > {1'b0, SPIKE_LIMIT};
  // Cannot overflow: at most 2^AVG_LOG2 12-bit codes are ever summed.
  assign sum_s    = acc_r + ACC_W'(code);

  // Accept/reject decision for the current strobe.
  always_comb begin
    accept_s = 1'b0;
    reject_s = 1'b0;
    if (hit_s) begin
      if (primed_s && spike_s) begin
        reject_s = 1'b1;
      end else begin
        accept_s = 1'b1;
      end
    end else begin
      accept_s = 1'b0;
    end
  end

  assign complete_s = accept_s && (cnt_r == CNT_LAST);

  // Watchdog next value: rejected samples do not feed the watchdog.
  always_comb begin
    wd_nxt_s = wd_r;
    if (accept_s) begin
      wd_nxt_s = 20'd0;
    end else if (wd_r == TIMEOUT) begin
      wd_nxt_s = TIMEOUT;
    end else begin
      wd_nxt_s = wd_r + 20'd1;
    end
  end

  // Rail state: leaving RUN drops "primed" so the next average is unconditional.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      EMPTY: begin
        if (complete_s) state_nxt_s = RUN;
        else            state_nxt_s = EMPTY;
      end
      RUN: begin
        if (complete_s)                 state_nxt_s = RUN;
        else if (wd_nxt_s == TIMEOUT)   state_nxt_s = STALE;
        else                            state_nxt_s = RUN;
      end
      STALE: begin
        if (complete_s) state_nxt_s = RUN;
        else            state_nxt_s = STALE;
      end
      default: state_nxt_s = EMPTY;
    endcase
  end

  // State, accumulator, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_in_n) begin
    if (!reset_in_n) begin
      state_r <= EMPTY;
      acc_r   <= '0;
      cnt_r   <= '0;
      wd_r    <= 20'd0;
      volt_r  <= 12'd0;
      drdy_r  <= 1'b0;
      stale_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      wd_r    <= wd_nxt_s;
      // stale tracks "watchdog == TIMEOUT" in the same cycle as the watchdog.
      stale_r <= (wd_nxt_s == TIMEOUT);
      drdy_r  <= complete_s;
      if (complete_s) begin
        acc_r  <= '0;
        cnt_r  <= '0;
        volt_r <= 12'(sum_s >> AVG_LOG2);
      end else if (accept_s) begin
        acc_r  <= sum_s;
        cnt_r  <= cnt_r + AVG_LOG2'(1);
      end else begin
        acc_r  <= acc_r;
        cnt_r  <= cnt_r;
      end
    end
  end

  assign volt   = volt_r;
  assign drdy   = drdy_r;
  assign stale  = stale_r;
  assign reject = reject_s;
endmodule

module adc_rail_filter #(
  parameter logic [4:0]  CH_A        = 5'd16,
  parameter logic [4:0]  CH_B        = 5'd17,
  parameter int          AVG_LOG2    = 2,
  parameter logic [11:0] SPIKE_LIMIT = 12'd400,
  parameter logic [19:0] TIMEOUT     = 20'd100000
) (
  input  logic        clk,
  input  logic        reset_in_n,
  input  logic [15:0] adc_data,
  input  logic [4:0]  adc_channel,
  input  logic        adc_eoc,
  output logic [11:0] volt_a,
  output logic [11:0] volt_b,
  output logic        drdy_a,
  output logic        drdy_b,
  output logic        stale_a,
  output logic        stale_b,
  output logic [7:0]  reject_cnt
);
  logic [11:0] code_s;
  logic [3:0]  adc_lsb_unused_s;
  logic        rej_a_s, rej_b_s;
  logic [1:0]  rej_inc_s;
  logic [8:0]  rej_sum_s;
  logic [7:0]  reject_cnt_r;

  assign code_s           = adc_data[15:4];
  assign adc_lsb_unused_s = adc_data[3:0];

  adc_rail_chan #(
    .CH(CH_A), .AVG_LOG2(AVG_LOG2), .SPIKE_LIMIT(SPIKE_LIMIT), .TIMEOUT(TIMEOUT)
  ) u_rail_a (
    .clk(clk), .reset_in_n(reset_in_n), .code(code_s), .adc_channel(adc_channel),
    .adc_eoc(adc_eoc), .volt(volt_a), .drdy(drdy_a), .stale(stale_a), .reject(rej_a_s)
  );

  adc_rail_chan #(
    .CH(CH_B), .AVG_LOG2(AVG_LOG2), .SPIKE_LIMIT(SPIKE_LIMIT), .TIMEOUT(TIMEOUT)
  ) u_rail_b (
    .clk(clk), .reset_in_n(reset_in_n), .code(code_s), .adc_channel(adc_channel),
    .adc_eoc(adc_eoc), .volt(volt_b), .drdy(drdy_b), .stale(stale_b), .reject(rej_b_s)
  );

  // Both rails may reject together (e.g. if CH_A == CH_B), hence a 2-bit step.
  assign rej_inc_s = {1'b0, rej_a_s} + {1'b0, rej_b_s};
  assign rej_sum_s = {1'b0, reject_cnt_r} + {7'd0, rej_inc_s};

  // Saturating reject counter.
  always_ff @(posedge clk or negedge reset_in_n) begin
    if (!reset_in_n) begin
      reject_cnt_r <= 8'd0;
    end else if (rej_sum_s[8]) begin
      reject_cnt_r <= 8'd255;
    end else begin
      reject_cnt_r <= rej_sum_s[7:0];
    end
  end

  assign reject_cnt = reject_cnt_r;
endmodule

// File: tb/tb_adc_rail_filter.sv
// ---------------------------------------------------------------------------
// tb_adc_rail_filter
//   Directed bench: a table of per-cycle vectors with hand-computed outputs,
//   followed by sequences for reset-mid-average, stale/recovery and reject
//   counter saturation. TIMEOUT is shortened to 1000 cycles for run time.
// ---------------------------------------------------------------------------
module tb_adc_rail_filter;
  localparam logic [19:0] TB_TIMEOUT = 20'd1000;

  logic        clk;
  logic        reset_in_n;
  logic [15:0] adc_data;
  logic [4:0]  adc_channel;
  logic        adc_eoc;
  logic [11:0] volt_a, volt_b;
  logic        drdy_a, drdy_b, stale_a, stale_b;
  logic [7:0]  reject_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  adc_rail_filter #(
    .CH_A(5'd16), .CH_B(5'd17), .AVG_LOG2(2), .SPIKE_LIMIT(12'd400), .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk(clk), .reset_in_n(reset_in_n), .adc_data(adc_data), .adc_channel(adc_channel),
    .adc_eoc(adc_eoc), .volt_a(volt_a), .volt_b(volt_b), .drdy_a(drdy_a), .drdy_b(drdy_b),
    .stale_a(stale_a), .stale_b(stale_b), .reject_cnt(reject_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        eoc;
    logic [4:0]  ch;
    logic [11:0] code;
    logic [11:0] va;
    logic [11:0] vb;
    logic        da;
    logic        db;
    logic [7:0]  rej;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic e, input logic [4:0] c, input logic [11:0] code,
                     input logic [11:0] va, input logic [11:0] vb, input logic da,
                     input logic db, input logic [7:0] rej);
    vec_t v;
    v.rst_n = r; v.eoc = e; v.ch = c; v.code = code;
    v.va = va; v.vb = vb; v.da = da; v.db = db; v.rej = rej;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Apply one cycle of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic r, input logic e, input logic [4:0] c, input logic [11:0] code);
    reset_in_n  = r;
    adc_eoc     = e;
    adc_channel = c;
    adc_data    = {code, 4'hA};
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 5'd0, 12'd0);
  endtask

  initial begin
    reset_in_n  = 1'b0;
    adc_eoc     = 1'b0;
    adc_channel = 5'd0;
    adc_data    = 16'd0;

    //   rst  eoc  ch     code       va        vb       da    db    rej
    add(1'b0, 1'b0, 5'd0,  12'd0,    12'd0,    12'd0,    1'b0, 1'b0, 8'd0);
    add(1'b1, 1'b1, 5'd16, 12'd3100, 12'd0,    12'd0,    1'b0, 1'b0, 8'd0);
    add(1'b1, 1'b1, 5'd16, 12'd3102, 12'd0,    12'd0,    1'b0, 1'b0, 8'd0);
    add(1'b1, 1'b1, 5'd16, 12'd3104, 12'd0,    12'd0,    1'b0, 1'b0, 8'd0);
    add(1'b1, 1'b1, 5'd16, 12'd3106, 12'd3103, 12'd0,    1'b1, 1'b0, 8'd0);
    add(1'b1, 1'b0, 5'd16, 12'd0,    12'd3103, 12'd0,    1'b0, 1'b0, 8'd0);
    add(1'b1, 1'b1, 5'd16, 12'd3150, 12'd3103, 12'd0,    1'b0, 1'b0, 8'd0);
    add(1'b1, 1'b1, 5'd16, 12'd3150, 12'd3103, 12'd0,    1'b0, 1'b0, 8'd0);
    add(1'b1, 1'b1, 5'd16, 12'd3150, 12'd3103, 12'd0,    1'b0, 1'b0, 8'd0);
    add(1'b1, 1'b1, 5'd16, 12'd3150, 12'd3150, 12'd0,    1'b1, 1'b0, 8'd0);
    // spike +450 rejected, then four clean samples
    add(1'b1, 1'b1, 5'd16, 12'd3600, 12'd3150, 12'd0,    1'b0, 1'b0, 8'd1);
    add(1'b1, 1'b1, 5'd16, 12'd3150, 12'd3150, 12'd0,    1'b0, 1'b0, 8'd1);
    add(1'b1, 1'b1, 5'd16, 12'd3150, 12'd3150, 12'd0,    1'b0, 1'b0, 8'd1);
    add(1'b1, 1'b1, 5'd16, 12'd3150, 12'd3150, 12'd0,    1'b0, 1'b0, 8'd1);
    add(1'b1, 1'b1, 5'd16, 12'd3150, 12'd3150, 12'd0,    1'b1, 1'b0, 8'd1);
    // limit boundaries: -401 rejected, +400 and -400 accepted, truncation 12601/4
    add(1'b1, 1'b1, 5'd16, 12'd2749, 12'd3150, 12'd0,    1'b0, 1'b0, 8'd2);
    add(1'b1, 1'b1, 5'd16, 12'd3550, 12'd3150, 12'd0,    1'b0, 1'b0, 8'd2);
    add(1'b1, 1'b1, 5'd16, 12'd2750, 12'd3150, 12'd0,    1'b0, 1'b0, 8'd2);
    add(1'b1, 1'b1, 5'd16, 12'd3150, 12'd3150, 12'd0,    1'b0, 1'b0, 8'd2);
    add(1'b1, 1'b1, 5'd16, 12'd3151, 12'd3150, 12'd0,    1'b1, 1'b0, 8'd2);
    // interleaved A / B / channel 3
    for (int k = 0; k < 3; k++) begin
      add(1'b1, 1'b1, 5'd16, 12'd3150, 12'd3150, 12'd0,  1'b0, 1'b0, 8'd2);
      add(1'b1, 1'b1, 5'd17, 12'd2000, 12'd3150, 12'd0,  1'b0, 1'b0, 8'd2);
      add(1'b1, 1'b1, 5'd3,  12'd4095, 12'd3150, 12'd0,  1'b0, 1'b0, 8'd2);
    end
    add(1'b1, 1'b1, 5'd16, 12'd3150, 12'd3150, 12'd0,    1'b1, 1'b0, 8'd2);
    add(1'b1, 1'b1, 5'd17, 12'd2000, 12'd3150, 12'd2000, 1'b0, 1'b1, 8'd2);
    add(1'b1, 1'b1, 5'd3,  12'd4095, 12'd3150, 12'd2000, 1'b0, 1'b0, 8'd2);
    // matching channel without eoc is ignored
    add(1'b1, 1'b0, 5'd16, 12'd0,    12'd3150, 12'd2000, 1'b0, 1'b0, 8'd2);
    // rail B spike boundaries (+401, -401)
    add(1'b1, 1'b1, 5'd17, 12'd2401, 12'd3150, 12'd2000, 1'b0, 1'b0, 8'd3);
    add(1'b1, 1'b1, 5'd17, 12'd1599, 12'd3150, 12'd2000, 1'b0, 1'b0, 8'd4);

    foreach (tbl[i]) begin
      cyc(tbl[i].rst_n, tbl[i].eoc, tbl[i].ch, tbl[i].code);
      check($sformatf("row%0d volt_a", i),     32'(volt_a),     32'(tbl[i].va));
      check($sformatf("row%0d volt_b", i),     32'(volt_b),     32'(tbl[i].vb));
      check($sformatf("row%0d drdy_a", i),     32'(drdy_a),     32'(tbl[i].da));
      check($sformatf("row%0d drdy_b", i),     32'(drdy_b),     32'(tbl[i].db));
      check($sformatf("row%0d reject_cnt", i), 32'(reject_cnt), 32'(tbl[i].rej));
      check($sformatf("row%0d stale", i),      32'({stale_a, stale_b}), 32'd0);
    end

    // Reset in the middle of an average discards the partial sum.
    cyc(1'b1, 1'b1, 5'd16, 12'd3150);
    cyc(1'b1, 1'b1, 5'd16, 12'd3150);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 5'd0, 12'd0);
      check($sformatf("rst%0d volts", k), 32'({volt_a, volt_b}), 32'd0);
      check($sformatf("rst%0d flags", k), 32'({drdy_a, drdy_b, stale_a, stale_b}), 32'd0);
      check($sformatf("rst%0d reject_cnt", k), 32'(reject_cnt), 32'd0);
    end
    cyc(1'b1, 1'b1, 5'd16, 12'd3150);
    check("post_rst s1 drdy_a", 32'(drdy_a), 32'd0);
    cyc(1'b1, 1'b1, 5'd16, 12'd3150);
    check("post_rst s2 drdy_a", 32'(drdy_a), 32'd0);
    idle();
    check("post_rst idle1 drdy_a", 32'(drdy_a), 32'd0);
    idle();
    check("post_rst idle2 drdy_a", 32'(drdy_a), 32'd0);
    check("post_rst volt_a", 32'(volt_a), 32'd0);
    cyc(1'b1, 1'b1, 5'd16, 12'd3150);
    check("post_rst s3 drdy_a", 32'(drdy_a), 32'd0);
    cyc(1'b1, 1'b1, 5'd16, 12'd3150);
    check("post_rst s4 drdy_a", 32'(drdy_a), 32'd1);
    check("post_rst s4 volt_a", 32'(volt_a), 32'd3150);

    // Prime rail B, let it go stale, then recover with a far-off level.
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 5'd17, 12'd2000);
    check("primeB volt_b", 32'(volt_b), 32'd2000);
    check("primeB drdy_b", 32'(drdy_b), 32'd1);
    for (int k = 0; k < 999; k++) idle();
    check("stale_b before timeout", 32'(stale_b), 32'd0);
    idle();
    check("stale_b at timeout", 32'(stale_b), 32'd1);
    check("stale_a at timeout", 32'(stale_a), 32'd1);
    for (int k = 0; k < 5; k++) idle();
    check("stale_b holds", 32'(stale_b), 32'd1);
    check("stale volt_b kept", 32'(volt_b), 32'd2000);
    cyc(1'b1, 1'b1, 5'd17, 12'd1000);
    check("recover s1 stale_b", 32'(stale_b), 32'd0);
    check("recover s1 reject_cnt", 32'(reject_cnt), 32'd0);
    check("recover s1 volt_b", 32'(volt_b), 32'd2000);
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 5'd17, 12'd1000);
    check("recover volt_b", 32'(volt_b), 32'd1000);
    check("recover drdy_b", 32'(drdy_b), 32'd1);
    check("recover stale_b", 32'(stale_b), 32'd0);

    // Re-prime rail A, then force 300 rejections.
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 5'd16, 12'd3150);
    check("reprimeA drdy_a", 32'(drdy_a), 32'd1);
    for (int k = 1; k <= 300; k++) begin
      cyc(1'b1, 1'b1, 5'd16, 12'd0);
      if (k == 254) check("sat 254", 32'(reject_cnt), 32'd254);
      if (k == 255) check("sat 255", 32'(reject_cnt), 32'd255);
    end
    check("sat 300", 32'(reject_cnt), 32'd255);
    check("sat volt_a", 32'(volt_a), 32'd3150);
    check("sat drdy_a", 32'(drdy_a), 32'd0);
    check("sat stale_a", 32'(stale_a), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
